display_write_arbiter: RTL

DISPLAY_WRITE_ARBITER -- requirements
Module: display_write_arbiter

---
 rtl/display_pkg.sv | 13 +
 rtl/display_write_fifo.sv | 50 +++++
 rtl/display_write_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared display constants and fill-engine state encoding.
package display_pkg;

  localparam int unsigned DISPLAY_ADDR_WIDTH = 12;
  localparam int unsigned DISPLAY_DATA_WIDTH = 16;
  localparam int unsigned DISPLAY_FIFO_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fillState_t;

endpackage

// File: rtl/display_write_fifo.sv
// Synchronous FIFO for buffered CPU display writes; DEPTH must be a power of two.
// The caller guarantees no push into a full FIFO without a same-cycle pop.
module display_write_fifo #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_c,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PtrWidth   = $clog2(DEPTH);
  localparam int unsigned CountWidth = PtrWidth + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [PtrWidth-1:0]   wrPtr;
  logic [PtrWidth-1:0]   rdPtr;
  logic [CountWidth-1:0] countNext_c;

  assign head_c      = mem[rdPtr];
  assign countNext_c = count + CountWidth'(push) - CountWidth'(pop);

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) wrPtr <= wrPtr + PtrWidth'(1);
      if (pop)  rdPtr <= rdPtr + PtrWidth'(1);
      count <= countNext_c;
      full  <= (countNext_c == CountWidth'(DEPTH));
      empty <= (countNext_c == '0);
    end
  end

endmodule

// File: rtl/display_write_arbiter.sv
// Arbitrates buffered CPU writes and an optional full-screen fill onto one display write port.
// Fill engine is built only when DISPLAY_WRITE_ARBITER_FILL_EN is defined.
module display_write_arbiter
  import display_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DISPLAY_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DISPLAY_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DISPLAY_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  fill_busy,
  output logic                  overflow,
  output logic                  dsp_en,
  output logic [ADDR_WIDTH-1:0] dsp_addr,
  output logic [DATA_WIDTH-1:0] dsp_data,
  input  logic                  dsp_ready
);

  localparam int unsigned EntryWidth = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned CountWidth = $clog2(FIFO_DEPTH) + 1;

  logic                  outFree_c;
  logic                  xfer_c;
  logic                  fifoPush_c;
  logic                  fifoPop_c;
  logic                  bypass_c;
  logic                  fillLoad_c;
  logic                  drop_c;
  logic                  fillWant_c;
  logic [EntryWidth-1:0] fifoHead_c;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [CountWidth-1:0] unusedFifoCount;
  logic [ADDR_WIDTH-1:0] fillAddr;
  logic [DATA_WIDTH-1:0] fillWord;

  assign xfer_c    = dsp_en & dsp_ready;
  assign outFree_c = ~dsp_en | dsp_ready;

  display_write_fifo #(
    .WIDTH (EntryWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifoPush_c),
    .pushData ({req_addr, req_data}),
    .pop      (fifoPop_c),
    .head_c   (fifoHead_c),
    .count    (unusedFifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

`ifdef DISPLAY_WRITE_ARBITER_FILL_EN
  fillState_t          fillState;
  fillState_t          fillStateNext;
  logic [ADDR_WIDTH:0] fillCnt;
  logic                fillLastOut;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fillState <= IDLE;
    else        fillState <= fillStateNext;
  end

  // FILL ends only once the last-address word has actually left the output register.
  always_comb begin
    fillStateNext = fillState;
    case (fillState)
      IDLE:    if (fill_start) fillStateNext = FILL;
      FILL:    if (xfer_c && fillLastOut) fillStateNext = IDLE;
      default: fillStateNext = IDLE;
    endcase
  end

  // Extra counter bit marks that every cell has been issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fillCnt     <= '0;
      fillWord    <= '0;
      fillLastOut <= 1'b0;
    end else begin
      if (fillState == IDLE && fill_start) begin
        fillCnt  <= '0;
        fillWord <= fill_data;
      end else if (fillLoad_c) begin
        fillCnt <= fillCnt + (ADDR_WIDTH + 1)'(1);
      end
      if (outFree_c) fillLastOut <= fillLoad_c & (&fillCnt[ADDR_WIDTH-1:0]);
    end
  end

  assign fillAddr   = fillCnt[ADDR_WIDTH-1:0];
  assign fillWant_c = (fillState == FILL) & ~fillCnt[ADDR_WIDTH];
  assign fill_busy  = (fillState == FILL);
`else
  logic unusedFill;

  assign unusedFill = ^{fill_start, fill_data};
  assign fillAddr   = '0;
  assign fillWord   = '0;
  assign fillWant_c = 1'b0;
  assign fill_busy  = 1'b0;
`endif

  // Reload priority: FIFO head, then an incoming write (bypass), then the fill.
  always_comb begin
    fifoPop_c  = 1'b0;
    fifoPush_c = 1'b0;
    bypass_c   = 1'b0;
    drop_c     = 1'b0;
    fillLoad_c = 1'b0;
    if (outFree_c && !fifoEmpty) fifoPop_c = 1'b1;
    if (req_valid) begin
      if (outFree_c && fifoEmpty)       bypass_c   = 1'b1;
      else if (!fifoFull || fifoPop_c)  fifoPush_c = 1'b1;
      else                              drop_c     = 1'b1;
    end
    fillLoad_c = fillWant_c & outFree_c & fifoEmpty & ~req_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dsp_en   <= 1'b0;
      dsp_addr <= '0;
      dsp_data <= '0;
      overflow <= 1'b0;
    end else begin
      if (fifoPop_c) begin
        dsp_en               <= 1'b1;
        {dsp_addr, dsp_data} <= fifoHead_c;
      end else if (bypass_c) begin
        dsp_en   <= 1'b1;
        dsp_addr <= req_addr;
        dsp_data <= req_data;
      end else if (fillLoad_c) begin
        dsp_en   <= 1'b1;
        dsp_addr <= fillAddr;
        dsp_data <= fillWord;
      end else if (xfer_c) begin
        dsp_en <= 1'b0;
      end
      if (drop_c) overflow <= 1'b1;
    end
  end

endmodule
